decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Decode/issue stage that drives the ALU. Consumes fetched RV32I instructions through a valid/ready handshake and reads the register file.
- Produces the ALU controls `operand_a`, `operand_b`, `funct3`, `funct7_bit5` and `alu_op`, plus writeback, memory and branch flags, all held in a single-entry output pipeline register.
- Inserts one bubble on load-use hazards and supports flush on redirect.

Parameters:
RESET_PC, 32'h0000_0000, value of `pc_out` after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  32  instruction word
in_pc  in  32  PC of in_instr
rs1_addr  out  5  combinational, in_instr[19:15]
rs2_addr  out  5  combinational, in_instr[24:20]
rs1_data  in  32  register file read data, same cycle
rs2_data  in  32  register file read data, same cycle
flush  in  1  kill held and incoming instruction
out_valid  out  1  output register holds an instruction
out_ready  in  1  execute stage consumes output
operand_a  out  32  ALU operand A
operand_b  out  32  ALU operand B
funct3  out  3  instr[14:12], passed through
funct7_bit5  out  1  SUB/SRA select
alu_op  out  4  ALU operation code
imm  out  32  sign-extended immediate
store_data  out  32  rs2_data for stores
pc_out  out  32  PC of held instruction
rd_addr  out  5  destination register
rd_we  out  1  writeback enable
is_load, is_store, is_branch, is_jump  out  1 each  class flags
illegal  out  1  unsupported opcode or funct

Behaviour:
- Reset (asynchronous, `rst`=1):
  - `out_valid`=0 and all registered outputs are 0.
  - `pc_out`=RESET_PC.
  - `alu_op`=4'b0000.
- Handshake:
  - Accept occurs when `in_valid` and `in_ready` are both 1.
  - `in_ready` = (!`out_valid` || `out_ready`) && !hazard && !`flush`.
  - Output transfer occurs when `out_valid` and `out_ready` are both 1.
  - On accept, the decoded fields load into the output register and `out_valid`=1 next cycle. Latency is 1 cycle.
  - On a transfer with no accept, `out_valid`=0 next cycle.
  - While `out_valid`=1 and `out_ready`=0, every output is held stable.
- Flush: `out_valid`=0 next cycle and the incoming instruction is not accepted. Flush has priority over accept and hold.
- alu_op encoding:
  - 0000 ADD/SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL/SRA, 0110 OR, 0111 AND, 1000 pass A.
  - For OP and OP-IMM, `alu_op` is taken from `funct3` as {1'b0, `funct3`}.
- funct7_bit5:
  - OP: instr[30].
  - OP-IMM: instr[30] only when `funct3`=101. It is forced to 0 for ADDI, so an immediate with bit 10 set never subtracts.
  - All other opcodes: 0.
- Operand selection by opcode:
  - OP: a=rs1, b=rs2, `rd_we`=1.
  - OP-IMM: a=rs1, b=I-imm, `rd_we`=1. For shifts, b holds shamt in [4:0].
  - LUI: `alu_op`=1000, a=U-imm, b=0, `rd_we`=1.
  - AUIPC: ADD, a=pc, b=U-imm, `rd_we`=1.
  - JAL: ADD, a=pc, b=4, `imm`=J-imm, `is_jump`=1, `rd_we`=1.
  - JALR: ADD, a=pc, b=4, `imm`=I-imm, `is_jump`=1, `rd_we`=1. funct3 must be 000.
  - LOAD: ADD, a=rs1, b=I-imm, `is_load`=1, `rd_we`=1.
  - STORE: ADD, a=rs1, b=S-imm, `store_data`=rs2, `is_store`=1, `rd_we`=0.
  - BRANCH: `alu_op`=0000 with `funct7_bit5`=1 (SUB), a=rs1, b=rs2, `imm`=B-imm, `is_branch`=1, `rd_we`=0.
- `rd_addr`=0 forces `rd_we`=0.
- Illegal instruction:
  - Triggered by an unknown opcode, OP with instr[31:25] not 0000000/0100000, a bad shift funct7, or invalid funct3 for LOAD, STORE or BRANCH.
  - Effect: `illegal`=1, `rd_we`=0, all class flags 0. The instruction still transfers.
- Load-use hazard:
  - hazard = `out_valid` && `is_load` && `rd_addr`!=0 && (`rd_addr` equals a used rs1 or a used rs2 of `in_instr`).
  - rs2 counts as used only for OP, STORE and BRANCH.
  - When the load transfers, a bubble follows (`out_valid`=0 for one cycle) and the dependent instruction is accepted on the next cycle.
- Reset mid-operation discards the held instruction immediately, without waiting for a clock edge.

Decomposition:
- Shared package `rv32i_pkg`:
  - Opcode constants: OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH.
  - ALU_ADD through ALU_PASSA constants, shared with the ALU.
- Sub-module `imm_gen`: combinational; generates I/S/B/U/J immediates from the instruction plus a format select.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), rs1_data=0 -> next cycle `out_valid`=1, `alu_op`=0000, `funct7_bit5`=0, a=0, b=5, `rd_addr`=1, `rd_we`=1.
2. SUB x3,x1,x2 (0x402081B3), rs1_data=10, rs2_data=3 -> `alu_op`=0000, `funct7_bit5`=1, a=10, b=3, `rd_addr`=3.
3. SRAI x5,x6,4 (0x40435293), rs1_data=0x80000000 -> `alu_op`=0101, `funct7_bit5`=1, b[4:0]=4, `rd_addr`=5.
4. Accept the instruction from scenario 1, then hold `out_ready`=0 for 3 cycles -> `in_ready`=0 and all outputs constant. Then set `out_ready`=1 -> the next instruction is accepted that cycle.
5. LW x1,0(x2) (0x00012083) followed by ADD x3,x1,x1 (0x001081B3), `out_ready`=1 -> exactly one `out_valid`=0 cycle between them, with `in_ready`=0 during the hazard.
6. Illegal 0xFFFFFFFF -> `illegal`=1, `rd_we`=0.
7. `flush` pulsed while `out_valid`=1 -> `out_valid`=0 next cycle.
8. `rst` asserted mid-stream -> `out_valid`=0 asynchronously and `pc_out`=RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation codes, immediate formats
// and the decoded-instruction record held in the decode/issue output register.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSA = 4'b1000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [31:0] imm;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        funct7_bit5;
        logic        rd_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } decoded_t;

    // Immediate layout used by each opcode; OP and unknown opcodes carry none.
    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, JALR, LOAD: return IMM_I;
            STORE:              return IMM_S;
            BRANCH:             return IMM_B;
            LUI, AUIPC:         return IMM_U;
            JAL:                return IMM_J;
            default:            return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Bundle of the fetch-side, register-file and execute-side signals of the
// decode/issue stage. The slave modport is the stage itself; the master
// modport is the surrounding pipeline (fetch, register file, execute).
interface decode_issue_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  funct3;
    logic        funct7_bit5;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] store_data;
    logic [31:0] pc_out;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;

    modport master (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, operand_a, operand_b,
               funct3, funct7_bit5, alu_op, imm, store_data, pc_out, rd_addr,
               rd_we, is_load, is_store, is_branch, is_jump, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, operand_a, operand_b,
               funct3, funct7_bit5, alu_op, imm, store_data, pc_out, rd_addr,
               rd_we, is_load, is_store, is_branch, is_jump, illegal
    );

endinterface

// File: rtl/decode_issue_imm_gen.sv
// Combinational RV32I immediate generator: sign-extends the I/S/B/U/J
// immediate selected by the format input. Opcode bits are not needed.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    // Reassemble the scattered immediate fields for the requested format.
    always_comb begin
        imm_o = 32'd0;
        case (fmt_i)
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'd0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decodes the fetched instruction, selects ALU
// operands from the register file, PC or immediate, and holds the result in
// a single-entry output register. Stalls one cycle on a load-use hazard and
// drops everything on flush.
module decode_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    decode_issue_if.slave bus
);

    import rv32i_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    imm_fmt_e    fmt;
    logic [31:0] imm;
    decoded_t    dec;
    logic        legal;
    logic        rs1_used;
    logic        rs2_used;
    logic        hazard;
    logic        accept;
    logic        transfer;
    logic        valid_q;
    logic        valid_d;
    decoded_t    dec_q;
    decoded_t    dec_d;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign funct3 = bus.in_instr[14:12];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];
    assign funct7 = bus.in_instr[31:25];
    assign fmt    = imm_fmt_of(opcode);

    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    imm_gen u_imm_gen (
        .instr_i (bus.in_instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    // Decode the incoming instruction into ALU controls, operands and flags.
    always_comb begin
        dec          = '0;
        legal        = 1'b1;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        dec.funct3   = funct3;
        dec.pc       = bus.in_pc;
        dec.rd_addr  = rd;
        dec.alu_op   = ALU_ADD;
        dec.imm      = imm;
        case (opcode)
            OP: begin
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                legal           = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                dec.alu_op      = {1'b0, funct3};
                dec.funct7_bit5 = bus.in_instr[30];
                dec.operand_a   = bus.rs1_data;
                dec.operand_b   = bus.rs2_data;
                dec.rd_we       = 1'b1;
            end
            OP_IMM: begin
                rs1_used = 1'b1;
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
                dec.alu_op      = {1'b0, funct3};
                dec.funct7_bit5 = (funct3 == 3'b101) && bus.in_instr[30];
                dec.operand_a   = bus.rs1_data;
                dec.operand_b   = imm;
                dec.rd_we       = 1'b1;
            end
            LUI: begin
                dec.alu_op    = ALU_PASSA;
                dec.operand_a = imm;
                dec.rd_we     = 1'b1;
            end
            AUIPC: begin
                dec.operand_a = bus.in_pc;
                dec.operand_b = imm;
                dec.rd_we     = 1'b1;
            end
            JAL: begin
                dec.operand_a = bus.in_pc;
                dec.operand_b = 32'd4;
                dec.is_jump   = 1'b1;
                dec.rd_we     = 1'b1;
            end
            JALR: begin
                rs1_used      = 1'b1;
                legal         = (funct3 == 3'b000);
                dec.operand_a = bus.in_pc;
                dec.operand_b = 32'd4;
                dec.is_jump   = 1'b1;
                dec.rd_we     = 1'b1;
            end
            LOAD: begin
                rs1_used      = 1'b1;
                legal         = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                dec.operand_a = bus.rs1_data;
                dec.operand_b = imm;
                dec.is_load   = 1'b1;
                dec.rd_we     = 1'b1;
            end
            STORE: begin
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                legal          = funct3 inside {3'b000, 3'b001, 3'b010};
                dec.operand_a  = bus.rs1_data;
                dec.operand_b  = imm;
                dec.store_data = bus.rs2_data;
                dec.is_store   = 1'b1;
            end
            BRANCH: begin
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                legal           = !(funct3 inside {3'b010, 3'b011});
                dec.funct7_bit5 = 1'b1;
                dec.operand_a   = bus.rs1_data;
                dec.operand_b   = bus.rs2_data;
                dec.is_branch   = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!legal) begin
            dec.illegal   = 1'b1;
            dec.rd_we     = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end
        if (rd == 5'd0) begin
            dec.rd_we = 1'b0;
        end
    end

    // A held load whose destination feeds a source the incoming instruction
    // actually reads must leave before that instruction can be decoded.
    assign hazard = valid_q && dec_q.is_load && (dec_q.rd_addr != 5'd0) &&
                    ((rs1_used && (dec_q.rd_addr == rs1)) ||
                     (rs2_used && (dec_q.rd_addr == rs2)));

    assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign transfer     = valid_q && bus.out_ready;

    // Output register next state: flush wins, then load new, then drain, else hold.
    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec;
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    // Output register with asynchronous clear back to the reset PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            dec_q    <= '0;
            dec_q.pc <= RESET_PC;
        end else begin
            valid_q  <= valid_d;
            dec_q    <= dec_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.operand_a   = dec_q.operand_a;
    assign bus.operand_b   = dec_q.operand_b;
    assign bus.funct3      = dec_q.funct3;
    assign bus.funct7_bit5 = dec_q.funct7_bit5;
    assign bus.alu_op      = dec_q.alu_op;
    assign bus.imm         = dec_q.imm;
    assign bus.store_data  = dec_q.store_data;
    assign bus.pc_out      = dec_q.pc;
    assign bus.rd_addr     = dec_q.rd_addr;
    assign bus.rd_we       = dec_q.rd_we;
    assign bus.is_load     = dec_q.is_load;
    assign bus.is_store    = dec_q.is_store;
    assign bus.is_branch   = dec_q.is_branch;
    assign bus.is_jump     = dec_q.is_jump;
    assign bus.illegal     = dec_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed testbench for decode_issue: a table of single instructions with
// hand-decoded expectations, followed by hold, load-use, flush and
// asynchronous-reset sequences.
module tb_decode_issue;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic        full;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] sd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic        st;
        logic        br;
        logic        jp;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   numChecks = 0;
    int   numFails  = 0;
    vec_t vecs[20];

    decode_issue_if bus();

    decode_issue #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic driveIdle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0000_0013;
        bus.in_pc     = 32'd0;
        bus.rs1_data  = 32'd0;
        bus.rs2_data  = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bus.in_valid  = 1'b1;
        bus.in_instr  = v.instr;
        bus.in_pc     = v.pc;
        bus.rs1_data  = v.rs1d;
        bus.rs2_data  = v.rs2d;
        bus.out_ready = 1'b1;
        #1;
        checkOutput($sformatf("v%0d.in_ready", idx), 32'(bus.in_ready), 32'd1);
        stepClk();
        bus.in_valid = 1'b0;
        checkOutput($sformatf("v%0d.out_valid", idx), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("v%0d.pc_out", idx), bus.pc_out, v.pc);
        checkOutput($sformatf("v%0d.rd_we", idx), 32'(bus.rd_we), 32'(v.we));
        checkOutput($sformatf("v%0d.illegal", idx), 32'(bus.illegal), 32'(v.ill));
        checkOutput($sformatf("v%0d.flags", idx),
                    32'({bus.is_load, bus.is_store, bus.is_branch, bus.is_jump}),
                    32'({v.ld, v.st, v.br, v.jp}));
        checkOutput($sformatf("v%0d.rd_addr", idx), 32'(bus.rd_addr), 32'(v.rd));
        if (v.full) begin
            checkOutput($sformatf("v%0d.operand_a", idx), bus.operand_a, v.a);
            checkOutput($sformatf("v%0d.operand_b", idx), bus.operand_b, v.b);
            checkOutput($sformatf("v%0d.alu_op", idx), 32'(bus.alu_op), 32'(v.alu));
            checkOutput($sformatf("v%0d.funct3", idx), 32'(bus.funct3), 32'(v.f3));
            checkOutput($sformatf("v%0d.funct7_bit5", idx), 32'(bus.funct7_bit5), 32'(v.f7b5));
            if (v.instr[6:0] != 7'b0110011) begin
                checkOutput($sformatf("v%0d.imm", idx), bus.imm, v.imm);
            end
            if (v.st) begin
                checkOutput($sformatf("v%0d.store_data", idx), bus.store_data, v.sd);
            end
        end
        stepClk();
        checkOutput($sformatf("v%0d.drained", idx), 32'(bus.out_valid), 32'd0);
    endtask

    // Safety net so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int bubbles;
        logic gotDep;

        //          instr         pc          rs1d          rs2d          full  a             b             imm           sd            alu   f3    f7b5  rd     we    ld    st    br    jp    ill
        vecs[0]  = '{32'h00500093, 32'h100, 32'd0,        32'd0,        1'b1, 32'd0,        32'd5,        32'd5,        32'd0,        4'h0, 3'd0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h402081B3, 32'h104, 32'd10,       32'd3,        1'b1, 32'd10,       32'd3,        32'd0,        32'd0,        4'h0, 3'd0, 1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h40435293, 32'h108, 32'h80000000, 32'd0,        1'b1, 32'h80000000, 32'h404,      32'h404,      32'd0,        4'h5, 3'd5, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h40000213, 32'h10C, 32'd0,        32'd0,        1'b1, 32'd0,        32'h400,      32'h400,      32'd0,        4'h0, 3'd0, 1'b0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h123453B7, 32'h110, 32'd0,        32'd0,        1'b1, 32'h12345000, 32'd0,        32'h12345000, 32'd0,        4'h8, 3'd5, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h00001417, 32'h200, 32'd0,        32'd0,        1'b1, 32'h200,      32'h1000,     32'h1000,     32'd0,        4'h0, 3'd1, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h008000EF, 32'h300, 32'd0,        32'd0,        1'b1, 32'h300,      32'd4,        32'd8,        32'd0,        4'h0, 3'd0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h00008067, 32'h400, 32'h55,       32'd0,        1'b1, 32'h400,      32'd4,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h00012083, 32'h500, 32'h1000,     32'd0,        1'b1, 32'h1000,     32'd0,        32'd0,        32'd0,        4'h0, 3'd2, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h00512423, 32'h504, 32'h2000,     32'hDEADBEEF, 1'b1, 32'h2000,     32'd8,        32'd8,        32'hDEADBEEF, 4'h0, 3'd2, 1'b0, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'hFE208EE3, 32'h508, 32'd7,        32'd9,        1'b1, 32'd7,        32'd9,        32'hFFFFFFFC, 32'd0,        4'h0, 3'd0, 1'b1, 5'd29, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h00208033, 32'h50C, 32'h11,       32'h22,       1'b1, 32'h11,       32'h22,       32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h0020E1B3, 32'h510, 32'hF0,       32'h0F,       1'b1, 32'hF0,       32'h0F,       32'd0,        32'd0,        4'h6, 3'd6, 1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'hFFF13093, 32'h514, 32'd1,        32'd0,        1'b1, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        4'h3, 3'd3, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'hFFFFFFFF, 32'h600, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{32'h022081B3, 32'h604, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{32'h40109093, 32'h608, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{32'h0001B083, 32'h60C, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{32'h00002063, 32'h610, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{32'h00009067, 32'h614, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        4'h0, 3'd0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        driveIdle();
        #12;
        checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset.pc_out", bus.pc_out, RESET_PC);
        checkOutput("reset.alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("reset.operand_a", bus.operand_a, 32'd0);
        checkOutput("reset.rd_we", 32'(bus.rd_we), 32'd0);
        checkOutput("reset.illegal", 32'(bus.illegal), 32'd0);
        rst = 1'b0;
        stepClk();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Hold: output frozen while execute back-pressures.
        driveIdle();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00500093;
        bus.in_pc    = 32'h700;
        stepClk();
        bus.out_ready = 1'b0;
        bus.in_instr  = 32'h00700113;
        bus.in_pc     = 32'h704;
        #1;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("hold%0d.in_ready", c), 32'(bus.in_ready), 32'd0);
            checkOutput($sformatf("hold%0d.out_valid", c), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("hold%0d.operand_b", c), bus.operand_b, 32'd5);
            checkOutput($sformatf("hold%0d.rd_addr", c), 32'(bus.rd_addr), 32'd1);
            checkOutput($sformatf("hold%0d.pc_out", c), bus.pc_out, 32'h700);
            stepClk();
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("hold.release_in_ready", 32'(bus.in_ready), 32'd1);
        stepClk();
        bus.in_valid = 1'b0;
        checkOutput("hold.next_operand_b", bus.operand_b, 32'd7);
        checkOutput("hold.next_rd_addr", 32'(bus.rd_addr), 32'd2);
        checkOutput("hold.next_pc_out", bus.pc_out, 32'h704);
        stepClk();

        // Load-use: LW x1 then ADD x3,x1,x1 needs exactly one bubble.
        driveIdle();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00012083;
        bus.rs1_data = 32'h1000;
        stepClk();
        bus.in_instr = 32'h00100193;
        #1;
        checkOutput("lu.addi_rs2_unused_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_instr = 32'h001081B3;
        #1;
        checkOutput("lu.hazard_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("lu.rs1_addr", 32'(bus.rs1_addr), 32'd1);
        checkOutput("lu.rs2_addr", 32'(bus.rs2_addr), 32'd1);
        checkOutput("lu.is_load", 32'(bus.is_load), 32'd1);
        bubbles = 0;
        gotDep  = 1'b0;
        for (int c = 0; c < 6 && !gotDep; c++) begin
            stepClk();
            if (bus.out_valid && bus.rd_addr == 5'd3) begin
                gotDep = 1'b1;
            end else if (!bus.out_valid) begin
                bubbles++;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("lu.dependent_issued", 32'(gotDep), 32'd1);
        checkOutput("lu.bubbles", 32'(bubbles), 32'd1);
        stepClk();

        // Flush kills the held instruction and blocks the incoming one.
        driveIdle();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00500093;
        stepClk();
        checkOutput("flush.pre_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.in_instr  = 32'h00700113;
        #1;
        checkOutput("flush.in_ready", 32'(bus.in_ready), 32'd0);
        stepClk();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush.out_valid", 32'(bus.out_valid), 32'd0);
        stepClk();
        checkOutput("flush.not_accepted", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset between clock edges.
        driveIdle();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00500093;
        bus.in_pc    = 32'h44;
        stepClk();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("arst.pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("arst.pc_out", bus.pc_out, RESET_PC);
        checkOutput("arst.rd_we", 32'(bus.rd_we), 32'd0);
        #2;
        rst = 1'b0;
        stepClk();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
